// File: rtl/axis_arbiter.sv
// axis_arbiter: round-robin burst arbiter merging COUNT AXI-stream inputs into one
// registered output stage tagged with a one-hot source grant.
module axis_arbiter #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4,
    parameter int BURST = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [COUNT*WIDTH-1:0] idata,
    input  logic [COUNT-1:0]       ivalid,
    output logic [COUNT-1:0]       iready,
    output logic [WIDTH-1:0]       odata,
    output logic                   ovalid,
    input  logic                   oready,
    output logic [COUNT-1:0]       ogrant
);
    localparam int GW = $clog2(COUNT);

    logic             locked_q, locked_d;
    logic [GW-1:0]    g_q, g_d, ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] odata_q, odata_d;
    logic             ovalid_q, ovalid_d;
    logic [COUNT-1:0] ogrant_q, ogrant_d;
    logic [GW-1:0]    win, src;
    logic             any, accept, xfer;

    function automatic logic [GW-1:0] nxt(input logic [GW-1:0] x);
        return (x == GW'(COUNT - 1)) ? '0 : x + 1'b1;
    endfunction

    // Scanning downwards leaves the first valid stream at or after ptr as the winner.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int i = COUNT - 1; i >= 0; i--) begin
            if (ivalid[(int'(ptr_q) + i) % COUNT]) begin
                win = GW'((int'(ptr_q) + i) % COUNT);
                any = 1'b1;
            end
        end
    end

    assign accept = !ovalid_q || oready;
    assign src    = locked_q ? g_q : win;
    assign xfer   = |(iready & ivalid);

    always_comb begin
        iready = '0;
        if (resetn && accept && (locked_q || any)) iready[src] = 1'b1;
    end

    always_comb begin
        locked_d = locked_q;
        g_d      = g_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        ogrant_d = ogrant_q;
        if (!locked_q) begin
            if (any && accept) begin
                g_d   = win;
                cnt_d = 8'd1;
                if (BURST > 1) locked_d = 1'b1;
                else ptr_d = nxt(win);
            end
        end else if (!ivalid[g_q]) begin
            locked_d = 1'b0;
            ptr_d    = nxt(g_q);
        end else if (accept) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == 8'(BURST)) begin
                locked_d = 1'b0;
                ptr_d    = nxt(g_q);
            end
        end
        if (xfer) begin
            odata_d  = idata[int'(src)*WIDTH +: WIDTH];
            ovalid_d = 1'b1;
            ogrant_d = COUNT'(1) << src;
        end else if (oready) begin
            ovalid_d = 1'b0;
            ogrant_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            locked_q <= 1'b0;
            g_q      <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ogrant_q <= '0;
        end else begin
            locked_q <= locked_d;
            g_q      <= g_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ogrant_q <= ogrant_d;
        end
    end

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ogrant = ogrant_q;
endmodule

// File: doc/axis_arbiter.md
# axis_arbiter

Round-robin arbiter that shares one AXI-stream-style output channel between COUNT input streams. It sits between several producers (counters, throttles, sensor sources) and a single consumer (LED register, UART, FIFO). Grants are held for bursts of up to BURST beats to reduce switching. Every accepted beat is re-emitted through one registered output stage that carries a one-hot source tag.

## Interface
- WIDTH, 8, data width per stream
- COUNT, 4, number of input streams (2..8)
- BURST, 4, maximum beats per grant (1..255)

- clock  input  1  single system clock, all logic on posedge
- resetn  input  1  asynchronous active-low reset
- idata  input  COUNT*WIDTH  packed input data, stream k at [k*WIDTH +: WIDTH]
- ivalid  input  COUNT  per-stream valid
- iready  output  COUNT  per-stream ready, combinational, at most one bit high
- odata  output  WIDTH  registered output data
- ovalid  output  1  registered output valid
- oready  input  1  downstream ready
- ogrant  output  COUNT  registered one-hot source of the current odata beat, 0 when ovalid=0

## Operation
- Beat transfer on any channel occurs when valid && ready are both high at a posedge.
- Output register accepts a new beat when accept = !ovalid || oready.
- State:
  - locked (1 bit)
  - grant index g (clog2(COUNT) bits)
  - beat counter cnt (8 bits)
  - round-robin pointer ptr
- Reset state: locked=0, g=0, cnt=0, ptr=0.
- Winner w: the first k with ivalid[k]=1, scanning k = ptr, ptr+1, … mod COUNT.
- UNLOCKED:
  - If any ivalid is high and accept=1: iready[w]=1 and the beat transfers; g<=w; cnt<=1.
  - locked<=1 if BURST>1; otherwise ptr<=w+1 mod COUNT.
- LOCKED:
  - iready[g]=accept; all other iready bits are 0.
  - If ivalid[g] && accept: transfer, cnt<=cnt+1. When cnt+1==BURST: locked<=0, ptr<=g+1 mod COUNT.
  - If ivalid[g]=0: locked<=0 and ptr<=g+1 mod COUNT in that cycle, with no transfer. Arbitration resumes next cycle.
- Output register:
  - On a transfer: odata<=source data, ovalid<=1, ogrant<=onehot(source).
  - Otherwise, if oready: ovalid<=0, ogrant<=0, odata holds.
- Input data must stay stable while valid is high and not accepted. Inputs may drop ivalid at any time without a transfer; the arbiter treats that as the end of the burst.
- iready must never assert on a channel other than the granted or winning one.

## Timing
- Input-to-output latency: 1 cycle. A beat accepted at edge N appears on odata/ovalid after edge N.
- Throughput: 1 beat/cycle while oready=1, including across a grant switch from UNLOCKED.
- Lock-release bubble: releasing because ivalid[g]=0 costs 1 idle arbitration cycle. Releasing on burst completion costs none, because the next beat arbitrates UNLOCKED in the following cycle.
- Backpressure: with ovalid=1 and oready=0, every iready is 0, and state, cnt, odata and ogrant hold.
- Reset values: odata=0, ovalid=0, ogrant=0. iready=0 while resetn=0.
- Reset mid-burst: all state returns to the reset values asynchronously and any beat held in the output register is dropped. After resetn rises, arbitration restarts from ptr=0.
- ptr wraps from COUNT-1 to 0. cnt never exceeds BURST.

## Test plan
- Single stream: ivalid=4'b0100, data 0x10,0x11,…, oready=1 → odata follows 1 cycle later with ogrant=4'b0100. Grant re-acquired every 4 beats with no bubble.
- All four streams always valid, BURST=4, oready=1 → output sequence 4 beats from ch0, 4 from ch1, 4 from ch2, 4 from ch3, then ch0 again, with no idle cycles.
- Stream 1 drops ivalid after 2 beats while streams 1 and 3 are valid → one idle cycle, then ch3 is granted. ch1 is not regranted before ch3 has had its turn.
- Backpressure: oready=0 for 5 cycles mid-burst → ovalid=1, and odata, ogrant, iready=0 all hold. Once oready=1 the burst resumes, with exactly 4 total beats from that channel and no beat lost or duplicated.
- BURST=1, streams 0 and 2 valid → output alternates ch0, ch2, ch0, … each cycle.
- resetn pulsed low mid-burst with ovalid=1 → ovalid, odata and ogrant go to 0 immediately. First grant after release goes to the lowest valid channel at or after index 0.
